// File: rtl/bus_addr_deser_pkg.sv
// Shared widths and FSM state encoding for the serial bus-to-bridge address path.
package bus_addr_deser_pkg;
  localparam int BB_ADDR_WIDTH_DEF      = 12;
  localparam int BUS_ADDR_WIDTH_DEF     = 16;
  localparam int BUS_MEM_ADDR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/bus_addr_deser_fold.sv
// Folds a full bus address into bridge format (slave select + offset); combinational.
// Range check only when ADDR_RANGE_CHECK_EN is defined, otherwise addr_err_o is 0.
module bus_addr_fold
  import bus_addr_deser_pkg::*;
#(
  parameter int BB_ADDR_WIDTH      = BB_ADDR_WIDTH_DEF,
  parameter int BUS_ADDR_WIDTH     = BUS_ADDR_WIDTH_DEF,
  parameter int BUS_MEM_ADDR_WIDTH = BUS_MEM_ADDR_WIDTH_DEF
) (
  input  logic [BUS_ADDR_WIDTH-1:0] bus_addr_i,
  output logic [BB_ADDR_WIDTH-1:0]  bb_addr_o,
  output logic                      addr_err_o
);
  assign bb_addr_o = {bus_addr_i[BUS_MEM_ADDR_WIDTH], bus_addr_i[BB_ADDR_WIDTH-2:0]};

`ifdef ADDR_RANGE_CHECK_EN
  // Bits that exist on the bus but have no home in the bridge format.
  function automatic logic [BUS_ADDR_WIDTH-1:0] err_mask();
    logic [BUS_ADDR_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < BUS_ADDR_WIDTH; i++) begin
      m[i] = ((i >= BB_ADDR_WIDTH-1) && (i <= BUS_MEM_ADDR_WIDTH-1)) || (i > BUS_MEM_ADDR_WIDTH);
    end
    return m;
  endfunction

  localparam logic [BUS_ADDR_WIDTH-1:0] ERR_MASK = err_mask();

  assign addr_err_o = |(bus_addr_i & ERR_MASK);
`else
  logic unused_bits;
  assign unused_bits = ^bus_addr_i;
  assign addr_err_o  = 1'b0;
`endif
endmodule

// File: rtl/bus_addr_deser.sv
// Serial (LSB-first) bus address deserializer to bridge format; result valid 1 cycle after last bit.
// Holds result until bb_ready, refusing serial bits meanwhile; abort flushes. Range check: ADDR_RANGE_CHECK_EN.
module bus_addr_deser
  import bus_addr_deser_pkg::*;
#(
  parameter int BB_ADDR_WIDTH      = BB_ADDR_WIDTH_DEF,
  parameter int BUS_ADDR_WIDTH     = BUS_ADDR_WIDTH_DEF,
  parameter int BUS_MEM_ADDR_WIDTH = BUS_MEM_ADDR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_addr_bit,
  input  logic                     s_addr_valid,
  output logic                     s_addr_ready,
  input  logic                     abort,
  output logic [BB_ADDR_WIDTH-1:0] bb_addr,
  output logic                     bb_valid,
  input  logic                     bb_ready,
  output logic                     addr_err
);
  localparam int CNT_W = $clog2(BUS_ADDR_WIDTH + 1);
  localparam int IDX_W = $clog2(BUS_ADDR_WIDTH);

  state_e                    state_q;
  logic [BUS_ADDR_WIDTH-1:0] shift_q;
  logic [BUS_ADDR_WIDTH-1:0] word_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [BB_ADDR_WIDTH-1:0]  bb_addr_q;
  logic                      bb_valid_q;
  logic                      addr_err_q;
  logic                      rdy_q;
  logic [BB_ADDR_WIDTH-1:0]  fold_addr;
  logic                      fold_err;
  logic                      last_bit;

  // Word as it will look once the bit on the wire lands, so the last bit folds in the same edge.
  always_comb begin
    word_d = shift_q;
    word_d[cnt_q[IDX_W-1:0]] = s_addr_bit;
  end

  assign last_bit = (cnt_q == CNT_W'(BUS_ADDR_WIDTH - 1));

  bus_addr_fold #(
    .BB_ADDR_WIDTH     (BB_ADDR_WIDTH),
    .BUS_ADDR_WIDTH    (BUS_ADDR_WIDTH),
    .BUS_MEM_ADDR_WIDTH(BUS_MEM_ADDR_WIDTH)
  ) u_fold (
    .bus_addr_i(word_d),
    .bb_addr_o (fold_addr),
    .addr_err_o(fold_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      bb_addr_q  <= '0;
      bb_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else if (abort) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bb_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_addr_valid) begin
            shift_q <= word_d;
            cnt_q   <= CNT_W'(1);
            state_q <= RECV;
          end
        end
        RECV: begin
          if (s_addr_valid) begin
            shift_q <= word_d;
            if (last_bit) begin
              bb_addr_q  <= fold_addr;
              addr_err_q <= fold_err;
              bb_valid_q <= 1'b1;
              rdy_q      <= 1'b0;
              cnt_q      <= '0;
              state_q    <= HOLD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (bb_ready) begin
            bb_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            rdy_q      <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign s_addr_ready = rdy_q;
  assign bb_addr      = bb_addr_q;
  assign bb_valid     = bb_valid_q;
  assign addr_err     = addr_err_q;
endmodule

// File: tb/tb_bus_addr_deser.sv
// Bench for bus_addr_deser: directed frames with literal expectations plus a randomized run
// checked every cycle against an arithmetic model of the address mapping.
module tb_bus_addr_deser;
`ifdef ADDR_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_addr_bit;
  logic        s_addr_valid;
  logic        s_addr_ready;
  logic        abort;
  logic [11:0] bb_addr;
  logic        bb_valid;
  logic        bb_ready;
  logic        addr_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bus_addr_deser dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_addr_bit  (s_addr_bit),
    .s_addr_valid(s_addr_valid),
    .s_addr_ready(s_addr_ready),
    .abort       (abort),
    .bb_addr     (bb_addr),
    .bb_valid    (bb_valid),
    .bb_ready    (bb_ready),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Mapping written directly from the address format rules.
  function automatic logic [11:0] exp_addr(input int w);
    return 12'(((w >> 12) & 1) * 2048 + (w % 2048));
  endfunction

  function automatic bit exp_err(input int w);
    return RC && ((((w >> 11) & 1) == 1) || (w >= 8192));
  endfunction

  // Model: count of bits gathered, their numeric value, and the held result.
  int          m_cnt  = 0;
  int          m_word = 0;
  bit          m_hold = 1'b0;
  bit          m_err  = 1'b0;
  logic [11:0] m_addr = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt  <= 0;
      m_word <= 0;
      m_hold <= 1'b0;
      m_err  <= 1'b0;
      m_addr <= '0;
    end else if (abort) begin
      m_cnt  <= 0;
      m_word <= 0;
      m_hold <= 1'b0;
      m_err  <= 1'b0;
    end else if (m_hold) begin
      if (bb_ready) begin
        m_hold <= 1'b0;
        m_err  <= 1'b0;
      end
    end else if (s_addr_valid) begin
      if (m_cnt == 15) begin
        m_addr <= exp_addr(m_word + int'(s_addr_bit) * 32768);
        m_err  <= exp_err(m_word + int'(s_addr_bit) * 32768);
        m_hold <= 1'b1;
        m_cnt  <= 0;
        m_word <= 0;
      end else begin
        m_word <= m_word + int'(s_addr_bit) * (1 << m_cnt);
        m_cnt  <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_s_addr_ready", s_addr_ready, !m_hold);
    check("cmp_bb_valid", bb_valid, m_hold);
    check("cmp_bb_addr", bb_addr, m_addr);
    check("cmp_addr_err", addr_err, m_err);
  end

  task automatic send_frame(input logic [15:0] w, input int gap_after, input int ngaps);
    int t0;
    t0 = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_after) begin
        for (int g = 0; g < ngaps; g++) begin
          @(negedge clk);
          #1 s_addr_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (i == 15) check("pre_last_bb_valid", bb_valid, 1'b0);
      #1;
      if (i == 0) t0 = cyc;
      s_addr_valid = 1'b1;
      s_addr_bit   = w[i];
    end
    @(negedge clk);
    check("frame_bb_valid", bb_valid, 1'b1);
    check("frame_latency", cyc - t0, 16 + ngaps);
    #1 s_addr_valid = 1'b0;
  endtask

  task automatic handshake();
    bb_ready = 1'b1;
    @(negedge clk);
    check("hs_bb_valid_drop", bb_valid, 1'b0);
    check("hs_ready_back", s_addr_ready, 1'b1);
    check("hs_err_clear", addr_err, 1'b0);
    #1 bb_ready = 1'b0;
  endtask

  initial begin
    rstn         = 1'b0;
    s_addr_bit   = 1'b0;
    s_addr_valid = 1'b0;
    abort        = 1'b0;
    bb_ready     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_addr_ready", s_addr_ready, 1'b1);
    check("rst_bb_valid", bb_valid, 1'b0);
    check("rst_bb_addr", bb_addr, 12'h000);
    check("rst_addr_err", addr_err, 1'b0);
    #1 rstn = 1'b1;

    send_frame(16'h1234, -1, 0);
    check("f1234_addr", bb_addr, 12'hA34);
    check("f1234_err", addr_err, 1'b0);
    handshake();

    send_frame(16'h0555, 8, 3);
    check("f0555_addr", bb_addr, 12'h555);
    check("f0555_err", addr_err, 1'b0);
    handshake();

    send_frame(16'h2000, -1, 0);
    check("f2000_addr", bb_addr, 12'h000);
    check("f2000_err", addr_err, RC);
    handshake();

    send_frame(16'h0800, -1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ready_low", s_addr_ready, 1'b0);
      check("hold_valid", bb_valid, 1'b1);
      check("hold_addr", bb_addr, 12'h000);
      check("hold_err", addr_err, RC);
      #1;
      s_addr_valid = 1'b1;
      s_addr_bit   = 1'($urandom_range(0, 1));
    end
    s_addr_valid = 1'b0;
    handshake();
    send_frame(16'h0003, -1, 0);
    check("after_hold_addr", bb_addr, 12'h003);
    check("after_hold_err", addr_err, 1'b0);
    handshake();

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      #1;
      s_addr_valid = 1'b1;
      s_addr_bit   = 1'b1;
    end
    @(negedge clk);
    #1;
    s_addr_valid = 1'b0;
    abort        = 1'b1;
    @(negedge clk);
    #1 abort = 1'b0;
    send_frame(16'h1001, -1, 0);
    check("abort_addr", bb_addr, 12'h801);
    check("abort_err", addr_err, 1'b0);
    handshake();

    send_frame(16'h1234, -1, 0);
    rstn = 1'b0;
    #1;
    check("rst_hold_valid", bb_valid, 1'b0);
    check("rst_hold_addr", bb_addr, 12'h000);
    check("rst_hold_err", addr_err, 1'b0);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_release_ready", s_addr_ready, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      s_addr_valid = ($urandom_range(0, 3) != 0);
      s_addr_bit   = 1'($urandom_range(0, 1));
      bb_ready     = ($urandom_range(0, 2) == 0);
      abort        = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    #1;
    s_addr_valid = 1'b0;
    abort        = 1'b0;
    bb_ready     = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_addr_deser.md
Name: bus_addr_deser

Overview:
- Bus-to-bridge address path: receives a bus address bit-serially from the serial system bus (LSB first).
- Assembles the full BUS_ADDR_WIDTH word.
- Folds it into the compact bridge address format: slave-select bit plus memory offset.
- Presents the result to the bridge with a valid/ready handshake. Inverse of the bridge-to-bus address mapping.

Parameters:
- BB_ADDR_WIDTH, 12, bridge address width; MSB = slave select, lower bits = memory offset.
- BUS_ADDR_WIDTH, 16, serial bus address width.
- BUS_MEM_ADDR_WIDTH, 12, bus slave memory field width; bus bit BUS_MEM_ADDR_WIDTH = slave select.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- s_addr_bit  input  1  serial address bit, LSB first
- s_addr_valid  input  1  s_addr_bit valid this cycle
- s_addr_ready  output  1  block accepts a serial bit this cycle
- abort  input  1  synchronous flush of a partial or held address
- bb_addr  output  BB_ADDR_WIDTH  converted bridge address
- bb_valid  output  1  bb_addr/addr_err valid
- bb_ready  input  1  bridge consumes the held address
- addr_err  output  1  address not representable in bridge format

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rstn).
- Reset values: state IDLE; shift register 0; bit counter 0; bb_addr 0; bb_valid 0; addr_err 0. s_addr_ready is 1 out of reset.
- States: IDLE, RECV, HOLD.
- IDLE: s_addr_ready=1. A bit is accepted when s_addr_valid=1; it is shifted into position 0. Counter becomes 1 and state goes to RECV.
- RECV: s_addr_ready=1. Each accepted bit is stored at index = counter, and counter increments.
  - Cycles with s_addr_valid=0 are gaps; no change.
  - When the bit with index BUS_ADDR_WIDTH-1 is accepted, bb_addr and addr_err are registered from the complete word in the same edge, and state goes to HOLD.
  - bb_valid rises the cycle after the last bit (latency 1).
- Mapping:
  - bb_addr[BB_ADDR_WIDTH-2:0] = bus[BB_ADDR_WIDTH-2:0]
  - bb_addr[BB_ADDR_WIDTH-1] = bus[BUS_MEM_ADDR_WIDTH]
- Error condition: addr_err=1 if any of bus[BUS_MEM_ADDR_WIDTH-1:BB_ADDR_WIDTH-1] or bus[BUS_ADDR_WIDTH-1:BUS_MEM_ADDR_WIDTH+1] is nonzero. With defaults these are bit 11 and bits 15:13. Mapped bits are still output when addr_err=1.
- HOLD: bb_valid=1 and s_addr_ready=0; serial bits presented are ignored.
  - bb_addr and addr_err stay stable until the handshake.
  - On bb_valid&&bb_ready, the next cycle has bb_valid=0, addr_err=0 and state IDLE. bb_addr keeps its last value.
  - No bypass: a new address cannot start in the handshake cycle.
- abort=1 (highest priority, synchronous): next state IDLE, counter 0, bb_valid 0, addr_err 0. abort wins over a simultaneous bit accept or handshake.
- rstn asserted mid-frame or in HOLD: immediate return to reset values; the partial word is discarded.
- Counter width: $clog2(BUS_ADDR_WIDTH+1). It never exceeds BUS_ADDR_WIDTH-1 outside HOLD.

Optional Feature:
- Macro ADDR_RANGE_CHECK_EN.
- Defined: addr_err computed as above.
- Undefined: addr_err is tied 0; the dropped bits are silently discarded and the mapping is unchanged.

Decomposition:
- Shared bus package: default widths (BB_ADDR_WIDTH=12, BUS_ADDR_WIDTH=16, BUS_MEM_ADDR_WIDTH=12) and the state encoding constants IDLE=2'd0, RECV=2'd1, HOLD=2'd2.
- One natural sub-module, bus_addr_fold: combinational mapping plus range check. The same function also serves as a reusable checker in the bench.

Test Plan:
- Serial 0x1234, no gaps → bb_valid 1 cycle after the 16th bit; bb_addr=0xA34, addr_err=0.
- Serial 0x0555 with s_addr_valid deasserted for 3 cycles mid-frame → bb_addr=0x555, addr_err=0; total latency extended by exactly 3 cycles.
- Serial 0x2000 → bb_addr=0x000. With ADDR_RANGE_CHECK_EN, addr_err=1; without it, addr_err=0.
- 0x0800 received, then bb_ready held 0 for 5 cycles while new bits are driven → s_addr_ready=0 and bb_addr stable at 0x000. With ADDR_RANGE_CHECK_EN, addr_err=1 (bit 11 set). On bb_ready=1, IDLE the next cycle and the ignored bits leave no trace.
- abort after 7 bits, then a full 0x1001 frame → bb_addr=0x801, with no corruption from the aborted bits.
- rstn pulsed low in HOLD → bb_valid, addr_err and bb_addr=0 immediately; s_addr_ready=1 after release.
